// File: rtl/fir_ctrl.sv
// Sequencer for the FIR datapath: gates per-sample shifts from the sample stream,
// streams a full coefficient set into the tap write port, and flags primed outputs.
module fir_ctrl #(
    parameter int NUM_TAPS       = 51,
    parameter int TAP_DATA_WIDTH = 16,
    parameter int TAP_ADDR_WIDTH = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_run,
    input  logic                      i_load_req,
    input  logic                      i_coef_valid,
    input  logic [TAP_DATA_WIDTH-1:0] i_coef_data,
    output logic                      o_coef_ready,
    input  logic                      i_sample_valid,
    output logic                      o_sample_ready,
    output logic                      o_fir_en,
    output logic                      o_tap_wr_en,
    output logic [TAP_ADDR_WIDTH-1:0] o_tap_wr_addr,
    output logic [TAP_DATA_WIDTH-1:0] o_tap_wr_data,
    output logic                      o_out_valid,
    output logic                      o_load_done,
    output logic [1:0]                o_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LOAD = 2'b10
    } state_t;

    localparam logic [TAP_ADDR_WIDTH-1:0] LAST_ADDR = TAP_ADDR_WIDTH'(NUM_TAPS - 1);

    state_t                      state_reg;
    state_t                      state_next;
    logic [TAP_ADDR_WIDTH-1:0]   coef_cnt_reg;
    logic [1:0]                  prime_reg;
    logic                        out_valid_reg;
    logic                        load_done_reg;

    logic sample_ready;
    logic fir_en;
    logic coef_ready;
    logic tap_wr_en;
    logic last_wr;
    logic load_entry;

    assign sample_ready = (state_reg == RUN) && !i_load_req;
    assign fir_en       = sample_ready && i_sample_valid;
    assign coef_ready   = (state_reg == LOAD);
    assign tap_wr_en    = coef_ready && i_coef_valid;
    assign last_wr      = tap_wr_en && (coef_cnt_reg == LAST_ADDR);
    assign load_entry   = (state_reg != LOAD) && (state_next == LOAD);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_load_req)  state_next = LOAD;
                else if (i_run)  state_next = RUN;
            end
            RUN: begin
                if (i_load_req)  state_next = LOAD;
                else if (!i_run) state_next = IDLE;
            end
            LOAD: begin
                // Reload requests are ignored here; only the final word ends the load.
                if (last_wr)     state_next = i_run ? RUN : IDLE;
            end
            default:             state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= IDLE;
            coef_cnt_reg  <= '0;
            prime_reg     <= 2'd0;
            out_valid_reg <= 1'b0;
            load_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            load_done_reg <= last_wr;
            out_valid_reg <= fir_en && (prime_reg == 2'd2);

            if (load_entry || last_wr)
                coef_cnt_reg <= '0;
            else if (tap_wr_en)
                coef_cnt_reg <= coef_cnt_reg + 1'b1;

            // New taps invalidate the pipeline contents; a plain stall does not.
            if (load_entry)
                prime_reg <= 2'd0;
            else if (fir_en && (prime_reg != 2'd2))
                prime_reg <= prime_reg + 2'd1;
        end
    end

    assign o_sample_ready = sample_ready;
    assign o_fir_en       = fir_en;
    assign o_coef_ready   = coef_ready;
    assign o_tap_wr_en    = tap_wr_en;
    assign o_tap_wr_addr  = coef_cnt_reg;
    assign o_tap_wr_data  = i_coef_data;
    assign o_out_valid    = out_valid_reg;
    assign o_load_done    = load_done_reg;
    assign o_state        = state_reg;

endmodule
